// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux_rr family.
package stream_mux_pkg;

  typedef logic mode_t;

  localparam mode_t MODE_FIXED = 1'b0;
  localparam mode_t MODE_RR    = 1'b1;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or after ptr wins.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int W = ch_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         grant_vld
);

  logic [W-1:0] idx;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N_CH-channel valid/ready stream mux with fixed or round-robin selection.
// Define STREAM_MUX_PKT_LOCK_EN to add s_last/m_last and packet-locked arbitration.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  localparam int CH_W  = ch_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] s_data,
  input  logic [N_CH-1:0]        s_valid,
  output logic [N_CH-1:0]        s_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N_CH-1:0]        s_last,
  output logic                   m_last,
`endif
  input  logic                   mode,
  input  logic [CH_W-1:0]        sel,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [CH_W-1:0]        m_ch
);

  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] arb_grant;
  logic [CH_W-1:0] pick;
  logic [CH_W-1:0] ptr_next;
  logic [N_CH-1:0] arb_req;
  logic            arb_vld;
  logic            pick_vld;
  logic            load_en;
  logic            xfer;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic            lock_vld;
  logic [CH_W-1:0] lock_ch;

  // While a packet is in flight only its own channel may compete.
  always_comb begin
    arb_req = s_valid;
    if (lock_vld) begin
      arb_req          = '0;
      arb_req[lock_ch] = s_valid[lock_ch];
    end
  end
`else
  assign arb_req = s_valid;
`endif

  rr_arbiter #(.N(N_CH)) u_arb (
    .req       (arb_req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_vld (arb_vld)
  );

  assign load_en = !m_valid || m_ready;

  always_comb begin
    pick     = sel;
    pick_vld = (int'(sel) < N_CH);
    if (mode == MODE_RR) begin
      pick     = arb_grant;
      pick_vld = arb_vld;
    end
  end

  always_comb begin
    s_ready = '0;
    if (rst_n && load_en && pick_vld) s_ready[pick] = 1'b1;
  end

  assign xfer     = |(s_valid & s_ready);
  assign ptr_next = (int'(pick) == N_CH - 1) ? '0 : pick + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_ch     <= '0;
      ptr      <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      m_last   <= 1'b0;
      lock_vld <= 1'b0;
      lock_ch  <= '0;
`endif
    end else begin
      if (xfer) begin
        m_valid <= 1'b1;
        m_data  <= s_data[pick*DATA_W +: DATA_W];
        m_ch    <= pick;
`ifdef STREAM_MUX_PKT_LOCK_EN
        m_last  <= s_last[pick];
`endif
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (xfer && mode == MODE_RR) begin
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (s_last[pick]) begin
          ptr      <= ptr_next;
          lock_vld <= 1'b0;
        end else begin
          lock_vld <= 1'b1;
          lock_ch  <= pick;
        end
`else
        ptr <= ptr_next;
`endif
      end

`ifdef STREAM_MUX_PKT_LOCK_EN
      // Any cycle spent in fixed mode abandons a partially sent packet lock.
      if (mode == MODE_FIXED) lock_vld <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N_CH=4 main instance, N_CH=3 boundary instance).
// Exercises packet lock when STREAM_MUX_PKT_LOCK_EN is defined.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] s_data;
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  m_ch;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [3:0]  s_last;
  logic        m_last;
  logic [2:0]  d3_s_last;
  logic        d3_m_last;
`endif

  logic [23:0] d3_s_data;
  logic [2:0]  d3_s_valid;
  logic [2:0]  d3_s_ready;
  logic        d3_mode;
  logic [1:0]  d3_sel;
  logic [7:0]  d3_m_data;
  logic        d3_m_valid;
  logic        d3_m_ready;
  logic [1:0]  d3_m_ch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .DATA_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .s_last  (s_last),
    .m_last  (m_last),
`endif
    .mode    (mode),
    .sel     (sel),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_ch    (m_ch)
  );

  stream_mux_rr #(.N_CH(3), .DATA_W(8)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (d3_s_data),
    .s_valid (d3_s_valid),
    .s_ready (d3_s_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .s_last  (d3_s_last),
    .m_last  (d3_m_last),
`endif
    .mode    (d3_mode),
    .sel     (d3_sel),
    .m_data  (d3_m_data),
    .m_valid (d3_m_valid),
    .m_ready (d3_m_ready),
    .m_ch    (d3_m_ch)
  );

  typedef struct {
    logic [3:0] valid;
    logic       md;
    logic [1:0] sl;
    logic       mready;
    logic [3:0] exp_ready;
    logic       exp_mv;
    logic [7:0] exp_md;
    logic [1:0] exp_mch;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic md, input logic [1:0] sl, input logic mr);
    s_valid = v;
    mode    = md;
    sel     = sl;
    m_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // Reference: ready is granted to one channel chosen by the selection rules when the output can load.
  function automatic logic [3:0] model_ready(input logic [3:0] v, input logic md, input logic [1:0] sl,
                                             input logic mvq, input logic mr, input int p);
    logic [3:0] r;
    int order[$];
    r = '0;
    if (mvq && !mr) return r;
    if (md == 1'b0) begin
      r[sl] = 1'b1;
      return r;
    end
    for (int k = 0; k < 4; k++) order.push_back((p + k) % 4);
    foreach (order[i]) begin
      if (v[order[i]]) begin
        r[order[i]] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  initial begin
    logic [3:0] exp_r;
    logic [3:0] acc;
    logic       mv_q;
    logic [7:0] md_q;
    logic [1:0] mch_q;
    int         ptr_q;
    int         ch;

    s_data     = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    s_valid    = 4'hF;
    mode       = 1'b1;
    sel        = 2'd0;
    m_ready    = 1'b1;
    d3_s_data  = {8'hC2, 8'hC1, 8'hC0};
    d3_s_valid = '0;
    d3_mode    = 1'b0;
    d3_sel     = 2'd0;
    d3_m_ready = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
    s_last     = '1;
    d3_s_last  = '1;
`endif

    vecs[0]  = '{4'hF,    1'b0, 2'd2, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[1]  = '{4'hF,    1'b0, 2'd2, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[2]  = '{4'hF,    1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[3]  = '{4'hF,    1'b1, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[4]  = '{4'hF,    1'b1, 2'd0, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[5]  = '{4'hF,    1'b1, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    vecs[6]  = '{4'hF,    1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[7]  = '{4'b1010, 1'b1, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[8]  = '{4'b1010, 1'b1, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    vecs[9]  = '{4'b1010, 1'b1, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[10] = '{4'b1010, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1};
    vecs[11] = '{4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 8'hA1, 2'd1};
    vecs[12] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0, 8'hA1, 2'd1};
    vecs[13] = '{4'b0010, 1'b0, 2'd1, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[14] = '{4'hF,    1'b0, 2'd3, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1};

    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_ready", s_ready, 4'b0000);
      checkOutput("rst_m_valid", m_valid, 1'b0);
      checkOutput("rst_m_data", m_data, 8'h00);
      checkOutput("rst_m_ch", m_ch, 2'd0);
    end
    rst_n = 1'b1;
    #2 checkOutput("post_rst_ready", s_ready, 4'b0001);
    tick();
    checkOutput("post_rst_m_valid", m_valid, 1'b1);
    checkOutput("post_rst_m_ch", m_ch, 2'd0);
    checkOutput("post_rst_m_data", m_data, 8'hA0);

    // A held beat must vanish on reset.
    m_ready = 1'b0;
    tick();
    do_reset();
    checkOutput("rst_discard_valid", m_valid, 1'b0);
    checkOutput("rst_discard_data", m_data, 8'h00);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].md, vecs[i].sl, vecs[i].mready);
      #2 checkOutput($sformatf("vec%0d_ready", i), s_ready, vecs[i].exp_ready);
      tick();
      checkOutput($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].exp_mv);
      checkOutput($sformatf("vec%0d_m_data", i), m_data, vecs[i].exp_md);
      checkOutput($sformatf("vec%0d_m_ch", i), m_ch, vecs[i].exp_mch);
    end

    do_reset();
    s_data = {8'h44, 8'h33, 8'h22, 8'h11};
    applyStimulus(4'hF, 1'b1, 2'd0, 1'b0);
    tick();
    checkOutput("bp_first_data", m_data, 8'h11);
    checkOutput("bp_first_ch", m_ch, 2'd0);
    for (int i = 0; i < 4; i++) begin
      #2 checkOutput("bp_ready", s_ready, 4'b0000);
      tick();
      checkOutput("bp_hold_data", m_data, 8'h11);
      checkOutput("bp_hold_valid", m_valid, 1'b1);
    end
    m_ready = 1'b1;
    #2 checkOutput("bp_release_ready", s_ready, 4'b0010);
    tick();
    checkOutput("bp_release_data", m_data, 8'h22);
    checkOutput("bp_release_ch", m_ch, 2'd1);
    #2 checkOutput("bp_next_ready", s_ready, 4'b0100);
    tick();
    checkOutput("bp_next_data", m_data, 8'h33);
    checkOutput("bp_next_valid", m_valid, 1'b1);

    d3_mode = 1'b0; d3_sel = 2'd3; d3_s_valid = 3'b111;
    #2 checkOutput("n3_sel_oob_ready", d3_s_ready, 3'b000);
    tick();
    checkOutput("n3_sel_oob_valid", d3_m_valid, 1'b0);
    d3_mode = 1'b1; d3_s_valid = 3'b010;
    #2 checkOutput("n3_rr_ch1_ready", d3_s_ready, 3'b010);
    tick();
    checkOutput("n3_rr_ch1_ch", d3_m_ch, 2'd1);
    d3_s_valid = 3'b001;
    #2 checkOutput("n3_wrap_ready", d3_s_ready, 3'b001);
    tick();
    checkOutput("n3_wrap_ch", d3_m_ch, 2'd0);
    checkOutput("n3_wrap_data", d3_m_data, 8'hC0);
    d3_s_valid = 3'b111;
    #2 checkOutput("n3_ptr1_ready", d3_s_ready, 3'b010);
    tick();
    checkOutput("n3_ptr1_ch", d3_m_ch, 2'd1);
    d3_s_valid = 3'b000;

`ifdef STREAM_MUX_PKT_LOCK_EN
    do_reset();
    s_last = 4'b1110;
    applyStimulus(4'b0011, 1'b1, 2'd0, 1'b1);
    tick();
    checkOutput("lock_b1_ch", m_ch, 2'd0);
    checkOutput("lock_b1_last", m_last, 1'b0);
    tick();
    checkOutput("lock_b2_ch", m_ch, 2'd0);
    s_last = 4'b1111;
    tick();
    checkOutput("lock_b3_ch", m_ch, 2'd0);
    checkOutput("lock_b3_last", m_last, 1'b1);
    tick();
    checkOutput("lock_after_ch", m_ch, 2'd1);
`endif

    do_reset();
    mv_q = 1'b0; md_q = 8'h00; mch_q = 2'd0; ptr_q = 0;
    for (int n = 0; n < 400; n++) begin
      s_data  = $urandom;
      s_valid = 4'($urandom);
      mode    = 1'($urandom_range(0, 1));
      sel     = 2'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      exp_r = model_ready(s_valid, mode, sel, mv_q, m_ready, ptr_q);
      #2;
      checkOutput("rnd_ready", s_ready, exp_r);
      checkOutput("rnd_m_valid", m_valid, mv_q);
      checkOutput("rnd_m_data", m_data, md_q);
      checkOutput("rnd_m_ch", m_ch, mch_q);
      acc = s_valid & exp_r;
      if (acc != 4'b0000) begin
        ch = 0;
        for (int i = 0; i < 4; i++) if (acc[i]) ch = i;
        mv_q  = 1'b1;
        md_q  = s_data[ch*8 +: 8];
        mch_q = 2'(ch);
        if (mode) ptr_q = (ch + 1) % 4;
      end else if (m_ready) begin
        mv_q = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
